// File: rtl/ped_crossing_signal.sv
// Pedestrian crossing front-end: debounces the button, raises a latched crossing request and drives WALK/DON'T WALK lamps plus a seconds countdown.
// Latency: button edge to ped_request_n low is 3 + DEBOUNCE_CYCLES cycles; lamps follow the controller's red onset on the next edge.
// Backpressure: none; the controller consumes the level request, and presses outside IDLE are dropped rather than queued.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   button_raw        asynchronous button, 0 = pressed
//   traffic_led[2:0]  controller lamp code (001 red, 010 orange, 100 green)
//   ped_request_n     crossing request to the controller, 0 = requesting
//   walk_led, dont_walk_led, waiting_led  pedestrian lamps
//   countdown[5:0]    remaining crossing seconds, 0 outside WALK/CLEAR
module ped_crossing_signal #(
    parameter int DEBOUNCE_CYCLES   = 270000,
    parameter int TICK_CYCLES       = 27000000,
    parameter int WALK_SECONDS      = 30,
    parameter int FLASH_SECONDS     = 10,
    parameter int FLASH_HALF_CYCLES = 13500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button_raw,
    input  logic [2:0] traffic_led,
    output logic       ped_request_n,
    output logic       walk_led,
    output logic       dont_walk_led,
    output logic       waiting_led,
    output logic [5:0] countdown
);

    localparam int DBW = (DEBOUNCE_CYCLES > 1)   ? $clog2(DEBOUNCE_CYCLES)   : 1;
    localparam int TW  = (TICK_CYCLES > 1)       ? $clog2(TICK_CYCLES)       : 1;
    localparam int FW  = (FLASH_HALF_CYCLES > 1) ? $clog2(FLASH_HALF_CYCLES) : 1;

    localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0]  TICK_LAST  = TW'(TICK_CYCLES - 1);
    localparam logic [FW-1:0]  FLASH_LAST = FW'(FLASH_HALF_CYCLES - 1);
    localparam logic [5:0]     WALK_CNT   = 6'(WALK_SECONDS);
    localparam logic [5:0]     FLASH_CNT  = 6'(FLASH_SECONDS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_WALK    = 2'd2,
        ST_CLEAR   = 2'd3
    } state_t;

    // ---------------------------------------------------------------
    // Input conditioning
    // ---------------------------------------------------------------
    logic           sync1_q, sync2_q;
    logic           db_q, db_d;
    logic           db_prev_q;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic           prev_red_q;
    logic           red, red_rise, press;

    assign red      = (traffic_led == 3'b001);
    assign red_rise = red & ~prev_red_q;
    // Registered edge detect on the debounced level gives a clean one-cycle pulse.
    assign press    = db_prev_q & ~db_q;

    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        if (sync2_q != db_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_d     = sync2_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            db_q       <= 1'b1;
            db_prev_q  <= 1'b1;
            db_cnt_q   <= '0;
            prev_red_q <= 1'b0;
        end else begin
            sync1_q    <= button_raw;
            sync2_q    <= sync1_q;
            db_q       <= db_d;
            db_prev_q  <= db_q;
            db_cnt_q   <= db_cnt_d;
            prev_red_q <= red;
        end
    end

    // ---------------------------------------------------------------
    // Crossing FSM with registered outputs
    // ---------------------------------------------------------------
    state_t        state_q, state_d;
    logic          req_n_q, req_n_d;
    logic          walk_q, walk_d;
    logic          dw_q, dw_d;
    logic          wait_q, wait_d;
    logic [5:0]    cd_q, cd_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [FW-1:0] flash_q, flash_d;
    logic [5:0]    cd_dec;
    logic          tick_done;
    logic          abort;

    assign cd_dec    = cd_q - 6'd1;
    assign tick_done = (tick_q == TICK_LAST);
    // Losing red while pedestrians are crossing drops straight back to a safe IDLE.
    assign abort     = ((state_q == ST_WALK) || (state_q == ST_CLEAR)) && !red;

    always_comb begin
        state_d = state_q;
        req_n_d = req_n_q;
        walk_d  = walk_q;
        dw_d    = dw_q;
        wait_d  = wait_q;
        cd_d    = cd_q;
        tick_d  = tick_q;
        flash_d = flash_q;

        case (state_q)
            ST_IDLE: begin
                req_n_d = 1'b1;
                walk_d  = 1'b0;
                dw_d    = 1'b1;
                wait_d  = 1'b0;
                cd_d    = '0;
                tick_d  = '0;
                flash_d = '0;
                if (press) begin
                    state_d = ST_REQUEST;
                    req_n_d = 1'b0;
                    wait_d  = 1'b1;
                end
            end

            ST_REQUEST: begin
                walk_d  = 1'b0;
                dw_d    = 1'b1;
                cd_d    = '0;
                tick_d  = '0;
                flash_d = '0;
                // Only a fresh red onset grants the crossing, never a red already showing.
                if (red_rise) begin
                    state_d = ST_WALK;
                    cd_d    = WALK_CNT;
                    req_n_d = 1'b1;
                    wait_d  = 1'b0;
                    walk_d  = 1'b1;
                    dw_d    = 1'b0;
                end
            end

            ST_WALK: begin
                if (tick_done) begin
                    tick_d = '0;
                    if (cd_q != 6'd0) begin
                        cd_d = cd_dec;
                        if (cd_dec == FLASH_CNT) begin
                            state_d = ST_CLEAR;
                            walk_d  = 1'b0;
                            dw_d    = 1'b1;
                            flash_d = '0;
                        end
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end

            ST_CLEAR: begin
                if (flash_q == FLASH_LAST) begin
                    flash_d = '0;
                    dw_d    = ~dw_q;
                end else begin
                    flash_d = flash_q + 1'b1;
                end
                if (tick_done) begin
                    tick_d = '0;
                    if (cd_q != 6'd0) begin
                        cd_d = cd_dec;
                        if (cd_dec == 6'd0) begin
                            state_d = ST_IDLE;
                            dw_d    = 1'b1;
                            flash_d = '0;
                        end
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Override last so it wins over a tick landing on the same cycle.
        if (abort) begin
            state_d = ST_IDLE;
            req_n_d = 1'b1;
            walk_d  = 1'b0;
            dw_d    = 1'b1;
            wait_d  = 1'b0;
            cd_d    = '0;
            tick_d  = '0;
            flash_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            req_n_q <= 1'b1;
            walk_q  <= 1'b0;
            dw_q    <= 1'b1;
            wait_q  <= 1'b0;
            cd_q    <= '0;
            tick_q  <= '0;
            flash_q <= '0;
        end else begin
            state_q <= state_d;
            req_n_q <= req_n_d;
            walk_q  <= walk_d;
            dw_q    <= dw_d;
            wait_q  <= wait_d;
            cd_q    <= cd_d;
            tick_q  <= tick_d;
            flash_q <= flash_d;
        end
    end

    assign ped_request_n = req_n_q;
    assign walk_led      = walk_q;
    assign dont_walk_led = dw_q;
    assign waiting_led   = wait_q;
    assign countdown     = cd_q;

endmodule

// File: tb/tb_ped_crossing_signal.sv
// Bench for ped_crossing_signal with small timing parameters.
// Inputs change on the falling edge; expected outputs are queued then and compared 1 time unit after the next rising edge.
// Covers reset, bounce rejection, press latency, full crossing with flashing, safety abort, red-already-on and mid-CLEAR reset.
module tb_ped_crossing_signal;

    typedef struct packed {
        logic       req_n;
        logic       walk;
        logic       dw;
        logic       wt;
        logic [5:0] cd;
    } out_t;

    typedef struct {
        logic       btn;
        logic [2:0] tl;
        logic       rst;
        out_t       exp;
        string      name;
    } vec_t;

    typedef struct {
        out_t  exp;
        string name;
    } sb_t;

    localparam out_t IDLE_O = {1'b1, 1'b0, 1'b1, 1'b0, 6'd0};
    localparam out_t REQ_O  = {1'b0, 1'b0, 1'b1, 1'b1, 6'd0};

    logic       clk;
    logic       reset;
    logic       button_raw;
    logic [2:0] traffic_led;
    logic       ped_request_n;
    logic       walk_led;
    logic       dont_walk_led;
    logic       waiting_led;
    logic [5:0] countdown;

    int   errors = 0;
    int   checks = 0;
    sb_t  sb[$];
    vec_t tbl[64];
    int   ntbl = 0;

    ped_crossing_signal #(
        .DEBOUNCE_CYCLES   (4),
        .TICK_CYCLES       (10),
        .WALK_SECONDS      (6),
        .FLASH_SECONDS     (3),
        .FLASH_HALF_CYCLES (5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .button_raw    (button_raw),
        .traffic_led   (traffic_led),
        .ped_request_n (ped_request_n),
        .walk_led      (walk_led),
        .dont_walk_led (dont_walk_led),
        .waiting_led   (waiting_led),
        .countdown     (countdown)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic out_t mk(logic rq, logic wk, logic dw, logic wt, int cd);
        out_t o;
        o.req_n = rq;
        o.walk  = wk;
        o.dw    = dw;
        o.wt    = wt;
        o.cd    = 6'(cd);
        return o;
    endfunction

    // Expected lamps k edges after the red onset that grants the crossing:
    // 10-cycle ticks from 6, CLEAR at 3 with 5-on/5-off flashing, IDLE at 0.
    function automatic out_t walk_exp(int k);
        int   cd;
        logic dw;
        if (k >= 60) return IDLE_O;
        cd = 6 - k / 10;
        if (k < 30) return mk(1'b1, 1'b1, 1'b0, 1'b0, cd);
        dw = (((k - 30) / 5) % 2) == 0;
        return mk(1'b1, 1'b0, dw, 1'b0, cd);
    endfunction

    function automatic void add(logic b, logic [2:0] t, logic r, out_t e, string nm);
        tbl[ntbl].btn  = b;
        tbl[ntbl].tl   = t;
        tbl[ntbl].rst  = r;
        tbl[ntbl].exp  = e;
        tbl[ntbl].name = nm;
        ntbl++;
    endfunction

    // Drive one cycle of inputs (called on a falling edge) and queue what the next rising edge must produce.
    task automatic cyc(input logic b, input logic [2:0] t, input logic r, input out_t e, input string nm);
        sb_t s;
        button_raw  = b;
        traffic_led = t;
        reset       = r;
        s.exp  = e;
        s.name = nm;
        sb.push_back(s);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            sb_t  s;
            out_t got;
            s   = sb.pop_front();
            got = {ped_request_n, walk_led, dont_walk_led, waiting_led, countdown};
            checks++;
            if (got !== s.exp) begin
                errors++;
                $display("FAIL %s: got req_n=%b walk=%b dw=%b wait=%b cd=%0d, expected req_n=%b walk=%b dw=%b wait=%b cd=%0d",
                         s.name, got.req_n, got.walk, got.dw, got.wt, got.cd,
                         s.exp.req_n, s.exp.walk, s.exp.dw, s.exp.wt, s.exp.cd);
            end
        end
    end

    initial begin
        reset       = 1'b1;
        button_raw  = 1'b1;
        traffic_led = 3'b100;

        // Test 1: single reset cycle.
        add(1'b1, 3'b100, 1'b1, IDLE_O, "t1_reset");
        add(1'b1, 3'b100, 1'b0, IDLE_O, "t1_after_reset");
        // Test 2: bounce every 2 cycles never survives debounce.
        for (int i = 0; i < 20; i++)
            add(((i / 2) % 2) == 0, 3'b100, 1'b0, IDLE_O, $sformatf("t2_bounce_%0d", i));
        for (int i = 0; i < 4; i++)
            add(1'b1, 3'b100, 1'b0, IDLE_O, $sformatf("t2_settle_%0d", i));
        // Test 3: steady press becomes visible exactly 6 edges after first 0 sample.
        for (int i = 0; i < 8; i++)
            add(1'b0, 3'b100, 1'b0, (i < 6) ? IDLE_O : REQ_O, $sformatf("t3_press_%0d", i));
        for (int i = 0; i < 8; i++)
            add(1'b1, 3'b100, 1'b0, REQ_O, $sformatf("t3_release_%0d", i));
        for (int i = 0; i < 10; i++)
            add(1'b0, 3'b100, 1'b0, REQ_O, $sformatf("t3_second_press_%0d", i));

        @(negedge clk);
        for (int i = 0; i < ntbl; i++)
            cyc(tbl[i].btn, tbl[i].tl, tbl[i].rst, tbl[i].exp, tbl[i].name);

        // Test 4: red onset in REQUEST runs the full crossing.
        for (int k = 0; k < 64; k++)
            cyc(1'b1, 3'b001, 1'b0, walk_exp(k), $sformatf("t4_cross_%0d", k));

        // Test 5: abort WALK when the lamp leaves red.
        for (int i = 0; i < 8; i++)
            cyc(1'b0, 3'b100, 1'b0, (i < 6) ? IDLE_O : REQ_O, $sformatf("t5_press_%0d", i));
        for (int i = 0; i < 2; i++)
            cyc(1'b1, 3'b100, 1'b0, REQ_O, $sformatf("t5_wait_%0d", i));
        for (int k = 0; k < 11; k++)
            cyc(1'b1, 3'b001, 1'b0, walk_exp(k), $sformatf("t5_walk_%0d", k));
        cyc(1'b1, 3'b010, 1'b0, IDLE_O, "t5_abort");
        for (int i = 0; i < 2; i++)
            cyc(1'b1, 3'b100, 1'b0, IDLE_O, $sformatf("t5_idle_%0d", i));

        // Test 6: press during an existing red does not start WALK.
        for (int i = 0; i < 2; i++)
            cyc(1'b1, 3'b001, 1'b0, IDLE_O, $sformatf("t6_red_idle_%0d", i));
        for (int i = 0; i < 8; i++)
            cyc(1'b0, 3'b001, 1'b0, (i < 6) ? IDLE_O : REQ_O, $sformatf("t6_press_%0d", i));
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 3'b001, 1'b0, REQ_O, $sformatf("t6_held_red_%0d", i));
        for (int i = 0; i < 2; i++)
            cyc(1'b1, 3'b100, 1'b0, REQ_O, $sformatf("t6_green_%0d", i));
        for (int k = 0; k < 33; k++)
            cyc(1'b1, 3'b001, 1'b0, walk_exp(k), $sformatf("t6_cross_%0d", k));
        cyc(1'b1, 3'b001, 1'b1, IDLE_O, "t6_reset_mid_clear");
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 3'b001, 1'b0, IDLE_O, $sformatf("t6_post_reset_%0d", i));

        @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ped_crossing_signal.md
Name: ped_crossing_signal

Overview:
- Pedestrian-side counterpart of the traffic light controller.
- Debounces the raw crossing button and presents a latched, active-low crossing request to the controller.
- Watches the controller's 3-bit lamp code and drives the WALK / DON'T WALK lamps, a waiting indicator and a seconds countdown.
- Sits between the board button and lamp pins and the controller's pedestrian input.

Parameters:
- DEBOUNCE_CYCLES, 270000, consecutive stable clk cycles needed to accept a new button level (10 ms at 27 MHz).
- TICK_CYCLES, 27000000, clk cycles per one-second tick.
- WALK_SECONDS, 30, total crossing window in ticks (1..63).
- FLASH_SECONDS, 10, final ticks of the window during which DON'T WALK flashes (< WALK_SECONDS).
- FLASH_HALF_CYCLES, 13500000, clk cycles per flash half-period.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- button_raw  in  1  asynchronous pedestrian button; 0 = pressed.
- traffic_led  in  3  controller lamp code: 001 red, 010 orange, 100 green; any other value is treated as not-red.
- ped_request_n  out  1  crossing request to the controller; 0 = requesting.
- walk_led  out  1  WALK lamp.
- dont_walk_led  out  1  DON'T WALK lamp.
- waiting_led  out  1  request-pending indicator.
- countdown  out  6  remaining crossing seconds; 0 outside WALK/CLEAR.

Behaviour:
- Reset (one synchronous cycle, checked at clk edge):
  - State IDLE.
  - ped_request_n=1, walk_led=0, dont_walk_led=1, waiting_led=0, countdown=0.
  - Debounced level=1, synchronizer flops=1, all counters 0, prev_red=0.
  - Reset mid-operation aborts any state on the next edge.
- Input conditioning:
  - button_raw passes through a 2-flop synchronizer.
  - Debounce counter increments while the synchronized value differs from the debounced level and clears when they match.
  - When the count reaches DEBOUNCE_CYCLES-1 with a still-differing value, the debounced level takes the synchronized value and the counter clears.
  - press = one-cycle pulse on a debounced 1->0 transition.
  - Latency from a clean raw edge to press: 2 + DEBOUNCE_CYCLES cycles.
- Red-entry detect:
  - red = (traffic_led == 3'b001).
  - prev_red is registered each cycle.
  - red_rise = red & ~prev_red.
- FSM (all outputs registered, updated on the same edge as the state):
  - IDLE:
    - dont_walk_led=1, other lamps 0, ped_request_n=1.
    - On press -> REQUEST.
  - REQUEST:
    - ped_request_n=0, waiting_led=1, dont_walk_led=1.
    - Further presses are ignored.
    - On red_rise -> WALK: load countdown=WALK_SECONDS, clear the tick counter, ped_request_n=1, waiting_led=0.
    - Being already in red on entry to REQUEST does not start WALK; only a new red onset does.
  - WALK:
    - walk_led=1, dont_walk_led=0.
    - The tick counter runs 0..TICK_CYCLES-1; at terminal count, countdown decrements.
    - If the decrement yields FLASH_SECONDS -> CLEAR, clearing the flash counter with the flash phase set to lit.
  - CLEAR:
    - walk_led=0.
    - dont_walk_led toggles every FLASH_HALF_CYCLES cycles, starting lit.
    - countdown keeps decrementing per tick.
    - When a decrement yields 0 -> IDLE with dont_walk_led=1 solid.
- Safety override: in WALK or CLEAR, if red==0 on any cycle, the next state is IDLE with:
  - walk_led=0, dont_walk_led=1, countdown=0.
  - Pending tick and flash counters cleared.
  - The override wins over a simultaneous tick.
- Presses in WALK or CLEAR are discarded, not queued.
- A press coinciding with the return to IDLE is discarded.
- Counters:
  - Tick and flash counters are sized by $clog2 of their parameters.
  - Both hold at 0 in IDLE and REQUEST.
  - Countdown never underflows; it is only decremented when nonzero.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES=4, TICK_CYCLES=10, WALK_SECONDS=6, FLASH_SECONDS=3, FLASH_HALF_CYCLES=5.
- Test 1: Reset asserted for 1 cycle, all inputs idle -> ped_request_n=1, dont_walk_led=1, walk_led=0, waiting_led=0, countdown=0.
- Test 2: Bounce button_raw 1/0 every 2 cycles for 20 cycles, then hold 1 -> no press; state stays IDLE, ped_request_n=1.
- Test 3: Hold button_raw=0 with traffic_led=100 -> ped_request_n=0 and waiting_led=1 exactly 6 cycles after the first 0 sample. Second press while in REQUEST -> no change.
- Test 4: In REQUEST, drive traffic_led=001 and hold -> next edge WALK: walk_led=1, countdown=6, ped_request_n=1. countdown reads 5, 4, 3 at 10-cycle intervals. At 3, dont_walk_led flashes 5 cycles on / 5 cycles off. At 0, returns to IDLE with dont_walk_led=1 solid.
- Test 5: During WALK with countdown=5, drive traffic_led=010 -> next edge walk_led=0, dont_walk_led=1, countdown=0, state IDLE.
- Test 6: Press while traffic_led already 001 -> stays in REQUEST, no WALK. Then drive 100 then 001 -> WALK starts on the 001 onset. Reset asserted mid-CLEAR -> all outputs at reset values on the following edge.
